// File: rtl/floo_eject_sink.sv
// Eject-side traffic sink: per-channel handshake with programmable
// backpressure, flit/packet counting, payload signature and packet tracking.
module floo_eject_sink #(
    parameter int unsigned NumChannels = 3,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned ThrWidth    = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic [1:0]                       mode_i,
    input  logic [ThrWidth-1:0]              throttle_i,
    input  logic                             clear_i,
    input  logic [NumChannels-1:0]           valid_i,
    output logic [NumChannels-1:0]           ready_o,
    input  logic [NumChannels*DataWidth-1:0] data_i,
    input  logic [NumChannels-1:0]           last_i,
    output logic [NumChannels*CntWidth-1:0]  flit_cnt_o,
    output logic [NumChannels*CntWidth-1:0]  pkt_cnt_o,
    output logic [NumChannels*DataWidth-1:0] sig_o,
    output logic [NumChannels-1:0]           in_pkt_o,
    output logic [NumChannels-1:0]           unexp_o
);

    localparam logic [1:0] ModeAccept   = 2'd0;
    localparam logic [1:0] ModeThrottle = 2'd2;

    typedef enum logic {
        StIdle,
        StInPkt
    } state_e;

    state_e                state_q [NumChannels];
    state_e                state_d [NumChannels];
    logic [ThrWidth-1:0]   thr_q   [NumChannels];
    logic [CntWidth-1:0]   flit_q  [NumChannels];
    logic [CntWidth-1:0]   pkt_q   [NumChannels];
    logic [DataWidth-1:0]  sig_q   [NumChannels];
    logic [NumChannels-1:0] unexp_q;
    logic [NumChannels-1:0] hs;

    // Ready depends only on registered throttle state and mode/enable
    always_comb begin
        ready_o = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (!enable_i) begin
                ready_o[c] = 1'b1;
            end else if (mode_i == ModeAccept) begin
                ready_o[c] = 1'b1;
            end else if (mode_i == ModeThrottle) begin
                ready_o[c] = (thr_q[c] == '0);
            end else begin
                ready_o[c] = 1'b0;
            end
        end
    end

    assign hs = valid_i & ready_o;

    // Packet-tracking FSM next state
    always_comb begin
        for (int c = 0; c < NumChannels; c++) begin
            state_d[c] = state_q[c];
            if (hs[c]) begin
                state_d[c] = last_i[c] ? StIdle : StInPkt;
            end
        end
    end

    // FSM state register; reset and clear return every channel to idle
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChannels; c++) begin
            if (rst_i || clear_i) begin
                state_q[c] <= StIdle;
            end else begin
                state_q[c] <= state_d[c];
            end
        end
    end

    // Throttle counters, statistics and signatures
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChannels; c++) begin
            if (rst_i || clear_i) begin
                thr_q[c]   <= '0;
                flit_q[c]  <= '0;
                pkt_q[c]   <= '0;
                sig_q[c]   <= '0;
                unexp_q[c] <= 1'b0;
            end else begin
                if (mode_i != ModeThrottle) begin
                    thr_q[c] <= '0;
                end else if (hs[c]) begin
                    thr_q[c] <= throttle_i;
                end else if (thr_q[c] != '0) begin
                    thr_q[c] <= thr_q[c] - ThrWidth'(1);
                end
                if (hs[c]) begin
                    if (flit_q[c] != '1) begin
                        flit_q[c] <= flit_q[c] + CntWidth'(1);
                    end
                    if (last_i[c] && (pkt_q[c] != '1)) begin
                        pkt_q[c] <= pkt_q[c] + CntWidth'(1);
                    end
                    sig_q[c] <= {sig_q[c][DataWidth-2:0], sig_q[c][DataWidth-1]}
                                ^ data_i[c*DataWidth +: DataWidth];
                    if (!enable_i) begin
                        unexp_q[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // Flatten per-channel state onto the output buses
    always_comb begin
        for (int c = 0; c < NumChannels; c++) begin
            flit_cnt_o[c*CntWidth +: CntWidth]  = flit_q[c];
            pkt_cnt_o[c*CntWidth +: CntWidth]   = pkt_q[c];
            sig_o[c*DataWidth +: DataWidth]     = sig_q[c];
            in_pkt_o[c]                         = (state_q[c] == StInPkt);
        end
    end

    assign unexp_o = unexp_q;

endmodule

// File: doc/floo_eject_sink.md
FLOO_EJECT_SINK -- requirements
Module: floo_eject_sink

Interface
REQ-001 SHALL have parameter NumChannels, default 3, number of independent eject channels (req, rsp, wide).
REQ-002 SHALL have parameter DataWidth, default 64, flit payload width per channel.
REQ-003 SHALL have parameter CntWidth, default 16, width of flit and packet counters.
REQ-004 SHALL have parameter ThrWidth, default 4, width of the throttle interval.
REQ-005 SHALL have port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port enable_i  in  1  sink armed; low means drain-and-flag.
REQ-008 SHALL have port mode_i  in  2  backpressure mode: 0 accept, 1 stall, 2 throttle, 3 treated as stall.
REQ-009 SHALL have port throttle_i  in  ThrWidth  idle cycles between accepted flits in throttle mode.
REQ-010 SHALL have port clear_i  in  1  synchronous clear of counters, signatures and flags.
REQ-011 SHALL have port valid_i  in  NumChannels  per-channel flit valid.
REQ-012 SHALL have port ready_o  out  NumChannels  per-channel flit ready.
REQ-013 SHALL have port data_i  in  NumChannels x DataWidth  per-channel flit payload.
REQ-014 SHALL have port last_i  in  NumChannels  per-channel last flit of packet.
REQ-015 SHALL have port flit_cnt_o  out  NumChannels x CntWidth  accepted flits per channel.
REQ-016 SHALL have port pkt_cnt_o  out  NumChannels x CntWidth  completed packets per channel.
REQ-017 SHALL have port sig_o  out  NumChannels x DataWidth  per-channel payload signature.
REQ-018 SHALL have port in_pkt_o  out  NumChannels  channel inside an unfinished packet.
REQ-019 SHALL have port unexp_o  out  NumChannels  sticky: flit accepted while enable_i low.

Function
REQ-020 SHALL define handshake on channel c as valid_i[c] and ready_o[c] both high in the same cycle.
REQ-021 SHALL drive ready_o[c] = 1 whenever enable_i is low, regardless of mode_i (drain).
REQ-022 SHALL, with enable_i high, drive ready_o[c] = 1 in mode 0 and 0 in modes 1 and 3.
REQ-023 SHALL, in mode 2, keep per-channel down-counter thr[c]; ready_o[c] = 1 iff thr[c] == 0.
REQ-024 SHALL load thr[c] with throttle_i on a handshake and decrement nonzero thr[c] otherwise; throttle_i = 0 gives ready every cycle.
REQ-025 SHALL hold thr[c] at 0 outside mode 2, so entering mode 2 gives ready immediately.
REQ-026 SHALL compute ready_o combinationally from registered state and mode_i/enable_i only, never from valid_i.
REQ-027 SHALL increment flit_cnt_o[c] by 1 per handshake, saturating at all-ones.
REQ-028 SHALL run a per-channel FSM IDLE/IN_PKT: IDLE->IN_PKT on handshake with last_i=0; IN_PKT->IDLE on handshake with last_i=1; otherwise hold; in_pkt_o[c] = (state == IN_PKT).
REQ-029 SHALL increment pkt_cnt_o[c] on each handshake with last_i=1 in either state, saturating at all-ones.
REQ-030 SHALL update sig_o[c] on handshake as rotate-left-by-1(sig_o[c]) XOR data_i[c].
REQ-031 SHALL set unexp_o[c] on a handshake while enable_i is low; it stays set until clear_i or reset.
REQ-032 SHALL update all counters, signatures and flags with one-cycle latency: visible the cycle after the handshake.
REQ-033 SHALL, on clear_i, zero counters, signatures, unexp_o and thr, and force FSMs to IDLE; clear_i wins over a same-cycle handshake, which completes but is not recorded.
REQ-034 SHALL keep channels fully independent; simultaneous handshakes on all channels are all recorded in the same cycle.

Reset
REQ-035 SHALL, while rst_i is high at a clock edge, zero flit_cnt_o, pkt_cnt_o, sig_o, unexp_o, thr and force all FSMs to IDLE (in_pkt_o = 0).
REQ-036 SHALL treat ready_o during reset purely per REQ-021/022 (thr = 0); reset asserted mid-packet discards the partial packet without counting it.

Verification
REQ-037 SHALL cover: mode 0, enable 1, 4 flits on ch0 with last on 4th -> flit_cnt 4, pkt_cnt 1, in_pkt 1 after flits 1-3, 0 after flit 4.
REQ-038 SHALL cover: mode 2, throttle_i=3, valid held high on ch1 for 12 cycles -> ready 1,0,0,0 repeating, 3 flits accepted.
REQ-039 SHALL cover: enable 0, mode 1, one flit on ch2 -> ready_o[2]=1, flit_cnt 1, unexp_o[2] sticky until clear_i.
REQ-040 SHALL cover: CntWidth=4, 20 single-flit packets -> flit_cnt and pkt_cnt saturate at 15.
REQ-041 SHALL cover: data 0x1 then 0x2 on ch0, DataWidth 64 -> sig 0x1, then 0x0 (rotl(0x1)=0x2 XOR 0x2); clear_i with same-cycle flit -> all zero.
REQ-042 SHALL cover: rst_i pulsed after 2 non-last flits -> in_pkt_o 0, counters 0, next flit starts a new packet.
